yduck_soc: RTL and testbench



---
 rtl/yduck_soc.sv | 68 ++++++
 tb/tb_yduck_soc.sv | 123 ++++++++++++
 2 files changed

// File: rtl/yduck_soc.sv
// yduck_soc: 16-bit single-cycle accumulator CPU with instruction ROM, data RAM and a GPIO port pair.
module yduck_soc #(
  parameter int    DW       = 16,
  parameter int    RAM_AW   = 7,
  parameter int    ROM_AW   = 7,
  parameter string ROM_FILE = "rom.hex"
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] gpio_in,
  output logic [DW-1:0] gpio_out
);
  logic [DW-1:0]     rom [2**ROM_AW];
  logic [DW-1:0]     ram [2**RAM_AW];
  logic [ROM_AW-1:0] pc;
  logic [DW-1:0]     acc;
  logic              c;
  logic              halt;
  logic [DW-1:0]     instr;
  logic [3:0]        op;
  logic [RAM_AW-1:0] ram_a;
  logic [ROM_AW-1:0] tgt;
  logic [DW-1:0]     mem;
  logic              z;
  logic [DW:0]       sum;
  logic [DW:0]       diff;
  initial for (int i = 0; i < 2**ROM_AW; i++) rom[i] = '0;
  assign instr = rom[pc];
  assign op    = instr[15:12];
  assign ram_a = instr[RAM_AW-1:0];
  assign tgt   = instr[ROM_AW-1:0];
  assign mem   = ram[ram_a];
  assign z     = acc == '0;
  assign sum   = {1'b0, acc} + {1'b0, mem};
  assign diff  = {1'b0, acc} - {1'b0, mem};
  always_ff @(posedge clk)
    if (!rst && !halt && op == 4'h3) ram[ram_a] <= acc;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pc       <= '0;
      acc      <= '0;
      c        <= 1'b0;
      halt     <= 1'b0;
      gpio_out <= '0;
    end else if (!halt) begin
      pc <= pc + 1'b1;
      case (op)
        4'h1: acc <= {4'h0, instr[11:0]};
        4'h2: acc <= mem;
        4'h4: {c, acc} <= sum;
        4'h5: {c, acc} <= diff;
        4'h6: acc <= acc & mem;
        4'h7: acc <= acc | mem;
        4'h8: acc <= acc ^ mem;
        4'h9: acc <= ~acc;
        4'hA: pc <= tgt;
        4'hB: if (z) pc <= tgt;
        4'hC: if (c) pc <= tgt;
        4'hD: acc <= gpio_in;
        4'hE: gpio_out <= acc;
        4'hF: begin
          halt <= 1'b1;
          pc   <= pc;
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_yduck_soc.sv
// tb_yduck_soc: directed programs for yduck_soc with hand-computed expected results.
module tb_yduck_soc;
   logic        clk;
   logic        rst;
   logic [15:0] gpio_in;
   logic [15:0] gpio_out;
   int          n_chk;
   int          n_err;
   logic [15:0] p[$];

   yduck_soc #(.ROM_FILE("")) dut (
      .clk(clk),
      .rst(rst),
      .gpio_in(gpio_in),
      .gpio_out(gpio_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // load the program under reset, release on a falling edge, run until HALT or budget
   task automatic run(input string tag, input logic [15:0] prog[$]);
      rst = 1'b1;
      #1;
      for (int i = 0; i < 128; i++) dut.rom[i] = (i < prog.size()) ? prog[i] : 16'h0000;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 200 && !dut.halt; i++) @(negedge clk);
      chk({tag, "_halt"}, 32'(dut.halt), 32'd1);
   endtask

   initial begin
      n_chk   = 0;
      n_err   = 0;
      rst     = 1'b1;
      gpio_in = 16'h0000;
      #1;
      for (int i = 0; i < 128; i++) dut.rom[i] = 16'h0000;
      #21;
      chk("rst_gpio", 32'(gpio_out), 32'h0000);
      chk("rst_pc", 32'(dut.pc), 32'h00);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("first_edge_pc", 32'(dut.pc), 32'h01);

      gpio_in = 16'hFA1C;
      p = '{16'hD000, 16'hE000, 16'hF000};
      run("in_out", p);
      chk("in_out_gpio", 32'(gpio_out), 32'hFA1C);
      chk("in_out_pc", 32'(dut.pc), 32'h02);
      repeat (3) @(negedge clk);
      gpio_in = 16'h1234;
      repeat (2) @(negedge clk);
      chk("halt_pc_frozen", 32'(dut.pc), 32'h02);
      chk("halt_gpio_frozen", 32'(gpio_out), 32'hFA1C);

      p = '{16'h1123, 16'h3005, 16'h1001, 16'h4005, 16'hE000, 16'hF000};
      run("add", p);
      chk("add_gpio", 32'(gpio_out), 32'h0124);
      chk("add_c", 32'(dut.c), 32'd0);

      // NOT of 0 gives FFFF; adding 1 wraps to zero with carry
      p = '{16'h1000, 16'h9000, 16'h3000, 16'h1001, 16'h4000, 16'hE000, 16'hF000};
      run("carry", p);
      chk("carry_gpio", 32'(gpio_out), 32'h0000);
      chk("carry_c", 32'(dut.c), 32'd1);
      chk("carry_z", 32'(dut.acc == 16'h0000), 32'd1);

      p = '{16'h1000, 16'hB003, 16'hE000, 16'h1055, 16'hE000, 16'hF000};
      run("jz", p);
      chk("jz_gpio", 32'(gpio_out), 32'h0055);
      chk("jz_pc", 32'(dut.pc), 32'h05);

      // 2 - 3 borrows: ACC=FFFF, C=1, then JC skips the LDI 77
      p = '{16'h1003, 16'h3001, 16'h1002, 16'h5001, 16'hC006, 16'h1077, 16'hE000, 16'hF000};
      run("sub_jc", p);
      chk("sub_jc_gpio", 32'(gpio_out), 32'hFFFF);
      chk("sub_jc_c", 32'(dut.c), 32'd1);

      // 3C ^ F0 = CC, store/reload, then OR F0 = FC
      p = '{16'h10F0, 16'h3002, 16'h103C, 16'h8002, 16'h3003, 16'h1000, 16'h2003,
            16'h7002, 16'hE000, 16'hF000};
      run("logic", p);
      chk("logic_gpio", 32'(gpio_out), 32'h00FC);
      chk("logic_ram3", 32'(dut.ram[3]), 32'h00CC);

      // PC wrap over NOPs, then an asynchronous reset pulse mid-cycle
      rst = 1'b1;
      #1;
      for (int i = 0; i < 128; i++) dut.rom[i] = 16'h0000;
      dut.rom[0] = 16'h1ABC;
      dut.rom[1] = 16'hE000;
      @(negedge clk);
      rst = 1'b0;
      repeat (127) @(posedge clk);
      #1;
      chk("wrap_pc_7f", 32'(dut.pc), 32'h7F);
      chk("wrap_gpio", 32'(gpio_out), 32'h0ABC);
      @(posedge clk);
      #1;
      chk("wrap_pc_00", 32'(dut.pc), 32'h00);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_gpio", 32'(gpio_out), 32'h0000);
      chk("async_rst_pc", 32'(dut.pc), 32'h00);
      @(negedge clk);
      rst = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
